tts_pipe: RTL and testbench
===========================

# tts_pipe

Parametrised successor to the tick-to-trade strategy wrapper. It accepts one decoded market-data message per handshake and resolves the symbol ID through a packed symbol RAM with a configurable number of slots per word. It then fetches a combined price/volume/order-template strategy word, performs a side-dependent price and volume comparison, and emits an order over a valid/ready interface with backpressure. Sits between the feed decoder and the order interface; both RAMs are external read ports with parametrised latency, and host-side writes are arbitrated outside this block.

## Interface
- SLOTS, 4, symbol entries per symbol-RAM word; power of 2, ≥1
- SLOT_W, 16, bits per entry; bit SLOT_W-1 = valid, [IDX_W-1:0] = strategy index; SLOT_W ≥ IDX_W+1
- SADDR_W, 14, symbol RAM address width; SYM_ID_W = SADDR_W + log2(SLOTS)
- IDX_W, 14, strategy RAM address width
- PRICE_W, 64; VOL_W, 32; ORDER_W, 128; TMPL_W = ORDER_W-PRICE_W-VOL_W-1 (≥1)
- RAM_LAT, 1, read latency (cycles, ≥1) of both RAMs
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- cfg_en  in  1  enable new message acceptance
- cnt_clr  in  1  synchronous clear of all counters
- msg_valid  in  1; msg_ready  out  1  message handshake
- msg_sym_id  in  SYM_ID_W; msg_price  in  PRICE_W; msg_vol  in  VOL_W; msg_side  in  1 (0 = ask, 1 = bid)
- srd_en  out  1; srd_addr  out  SADDR_W; srd_data  in  SLOTS*SLOT_W  symbol RAM read port
- trd_en  out  1; trd_addr  out  IDX_W; trd_data  in  TMPL_W+PRICE_W+VOL_W  strategy RAM read port; word = {tmpl, limit_px, min_vol}
- ord_valid  out  1; ord_ready  in  1; ord_data  out  ORDER_W = {tmpl, side, msg_price, msg_vol}
- cnt_msg, cnt_ord, cnt_miss, cnt_nohit  out  32 each  saturating statistics

## Operation
- msg_ready = cfg_en && state==IDLE (combinational). On accept, latch sym_id/price/vol/side; cnt_msg++.
- FSM: IDLE → SRD → SWAIT → TRD → TWAIT → CMP → OUT → IDLE.
- SRD (1 cycle): srd_en=1, srd_addr = sym_id >> log2(SLOTS). SWAIT: count RAM_LAT cycles. In the last cycle, select slot sym_id[log2(SLOTS)-1:0] from srd_data and register index/valid.
- If entry valid=0: cnt_miss++, go to IDLE; no strategy read.
- TRD (1 cycle): trd_en=1, trd_addr = index. TWAIT: RAM_LAT cycles; register trd_data.
- CMP: hit = (side==0 ? price ≤ limit_px : price ≥ limit_px) && vol ≥ min_vol. Unsigned compares, full width.
  - hit → OUT with ord_valid=1.
  - no hit → cnt_nohit++, go to IDLE.
- OUT: hold ord_valid and ord_data stable until ord_ready. On handshake, cnt_ord++ and go to IDLE.
- srd_en/trd_en are single-cycle pulses; addresses are held stable while in the corresponding WAIT state.
- Counters saturate at 32'hFFFF_FFFF. cnt_clr wins over a same-cycle increment.
- cfg_en deasserted mid-message: the current message completes normally; no new accepts.
- Reset (any state, including OUT): state IDLE. ord_valid, srd_en, trd_en, all counters = 0. msg_ready = cfg_en after reset. Latched message data are don't-care.

## Timing
- Accept at cycle T: srd_en at T+1; slot decode at T+1+RAM_LAT; trd_en at T+2+RAM_LAT; compare at T+2+2·RAM_LAT; ord_valid at T+3+2·RAM_LAT (T+5 for RAM_LAT=1).
- Miss: IDLE (msg_ready high) at T+2+RAM_LAT. No-hit: IDLE at T+3+2·RAM_LAT.
- ord_ready high in the first ord_valid cycle: IDLE next cycle; next accept possible at T+4+2·RAM_LAT.
- Single message in flight; no overlap between messages.

## Test plan
- Reset, cfg_en=1: all outputs 0 except msg_ready=1. Symbol word 0 slot 1 = 16'h8005, strategy[5] = {tmpl=31'h1234, limit=100, min_vol=10}. Message id=1, ask, price=99, vol=10 → srd_addr=0 at T+1, trd_addr=5 at T+3, ord_valid at T+5 with ord_data={31'h1234,1'b0,64'd99,32'd10}; cnt_ord=1.
- Same symbol, bid, price=99 → no order, cnt_nohit=1. Bid, price=100 → order. Ask, vol=9 → no order.
- id=6 with slot 2 entry valid bit clear → no trd_en, cnt_miss=1, msg_ready high at T+3.
- Hold ord_ready=0 for 7 cycles → ord_valid/ord_data stable, msg_ready=0; release → one handshake, cnt_ord +1 only.
- RAM_LAT=3, SLOTS=8 build: id=8'h1B → srd_addr=3, slot 3, ord_valid at T+9.
- cnt_msg preset near saturation by 2^32 stimulus-forced sequence or force → holds at FFFF_FFFF. cnt_clr coincident with accept → 0. reset_n low during OUT → ord_valid=0 next cycle, counters 0.

Source files
------------

// File: rtl/tts_pipe.sv
// Tick-to-trade strategy pipe: symbol lookup in a packed slot RAM, strategy fetch,
// side-dependent price/volume compare, and order emission with backpressure.
module tts_pipe #(
  parameter int SLOTS   = 4,
  parameter int SLOT_W  = 16,
  parameter int SADDR_W = 14,
  parameter int IDX_W   = 14,
  parameter int PRICE_W = 64,
  parameter int VOL_W   = 32,
  parameter int ORDER_W = 128,
  parameter int RAM_LAT = 1,
  localparam int SLOT_BITS = $clog2(SLOTS),
  localparam int SYM_ID_W  = SADDR_W + SLOT_BITS,
  localparam int TMPL_W    = ORDER_W - PRICE_W - VOL_W - 1,
  localparam int STRAT_W   = TMPL_W + PRICE_W + VOL_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_en,
  input  logic                      cnt_clr,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  logic [SYM_ID_W-1:0]       msg_sym_id,
  input  logic [PRICE_W-1:0]        msg_price,
  input  logic [VOL_W-1:0]          msg_vol,
  input  logic                      msg_side,
  output logic                      srd_en,
  output logic [SADDR_W-1:0]        srd_addr,
  input  logic [SLOTS*SLOT_W-1:0]   srd_data,
  output logic                      trd_en,
  output logic [IDX_W-1:0]          trd_addr,
  input  logic [STRAT_W-1:0]        trd_data,
  output logic                      ord_valid,
  input  logic                      ord_ready,
  output logic [ORDER_W-1:0]        ord_data,
  output logic [31:0]               cnt_msg,
  output logic [31:0]               cnt_ord,
  output logic [31:0]               cnt_miss,
  output logic [31:0]               cnt_nohit
);

  typedef enum logic [2:0] {
    S_IDLE, S_SRD, S_SWAIT, S_TRD, S_TWAIT, S_CMP, S_OUT
  } state_t;

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     lat_cnt_q;
  logic                 lat_last;

  logic [SYM_ID_W-1:0]  sym_id_q;
  logic [PRICE_W-1:0]   price_q;
  logic [VOL_W-1:0]     vol_q;
  logic                 side_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ORDER_W-1:0]   ord_data_q;

  logic                 entry_valid;
  logic [IDX_W-1:0]     entry_idx;

  logic [TMPL_W-1:0]    s_tmpl;
  logic [PRICE_W-1:0]   s_limit;
  logic [VOL_W-1:0]     s_min_vol;
  logic                 hit;

  logic                 accept, ev_miss, ev_nohit, ev_ord;

  assign lat_last = (lat_cnt_q == CNT_W'(RAM_LAT - 1));

  // Slot selection reads only the valid bit and index bits of the addressed entry.
  generate
    if (SLOT_BITS > 0) begin : g_multi_slot
      logic [SLOT_BITS-1:0] slot_sel;
      assign slot_sel    = sym_id_q[SLOT_BITS-1:0];
      assign entry_valid = srd_data[int'(slot_sel) * SLOT_W + SLOT_W - 1];
      assign entry_idx   = srd_data[int'(slot_sel) * SLOT_W +: IDX_W];
    end else begin : g_single_slot
      assign entry_valid = srd_data[SLOT_W-1];
      assign entry_idx   = srd_data[IDX_W-1:0];
    end
  endgenerate

  assign s_tmpl    = trd_data[STRAT_W-1 -: TMPL_W];
  assign s_limit   = trd_data[VOL_W +: PRICE_W];
  assign s_min_vol = trd_data[VOL_W-1:0];

  assign hit = (side_q ? (price_q >= s_limit) : (price_q <= s_limit)) &&
               (vol_q >= s_min_vol);

  assign srd_addr = sym_id_q[SYM_ID_W-1:SLOT_BITS];
  assign trd_addr = idx_q;
  assign ord_data = ord_data_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    msg_ready = 1'b0;
    srd_en    = 1'b0;
    trd_en    = 1'b0;
    ord_valid = 1'b0;
    accept    = 1'b0;
    ev_miss   = 1'b0;
    ev_nohit  = 1'b0;
    ev_ord    = 1'b0;
    case (state_q)
      S_IDLE: begin
        msg_ready = cfg_en;
        if (msg_valid && cfg_en) begin
          accept  = 1'b1;
          state_d = S_SRD;
        end
      end
      S_SRD: begin
        srd_en  = 1'b1;
        state_d = S_SWAIT;
      end
      S_SWAIT: begin
        if (lat_last) begin
          if (entry_valid) begin
            state_d = S_TRD;
          end else begin
            ev_miss = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_TRD: begin
        trd_en  = 1'b1;
        // Strategy data is consumed in CMP, so only RAM_LAT-1 pure wait cycles remain.
        state_d = (RAM_LAT > 1) ? S_TWAIT : S_CMP;
      end
      S_TWAIT: begin
        if (lat_last) state_d = S_CMP;
      end
      S_CMP: begin
        if (hit) begin
          state_d = S_OUT;
        end else begin
          ev_nohit = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_OUT: begin
        ord_valid = 1'b1;
        if (ord_ready) begin
          ev_ord  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter: SWAIT counts 0..RAM_LAT-1, TWAIT counts 1..RAM_LAT-1.
  always_ff @(posedge clk) begin
    if (!reset_n)                lat_cnt_q <= '0;
    else if (state_q == S_SRD)   lat_cnt_q <= '0;
    else if (state_q == S_TRD)   lat_cnt_q <= CNT_W'(1);
    else                         lat_cnt_q <= lat_cnt_q + CNT_W'(1);
  end

  // NOTE: datapath registers are reset as well so all outputs read zero after reset;
  // the cost is small because there is no array storage in this block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sym_id_q   <= '0;
      price_q    <= '0;
      vol_q      <= '0;
      side_q     <= 1'b0;
      idx_q      <= '0;
      ord_data_q <= '0;
    end else begin
      if (accept) begin
        sym_id_q <= msg_sym_id;
        price_q  <= msg_price;
        vol_q    <= msg_vol;
        side_q   <= msg_side;
      end
      if (state_q == S_SWAIT && lat_last) idx_q <= entry_idx;
      if (state_q == S_CMP && hit)         ord_data_q <= {s_tmpl, side_q, price_q, vol_q};
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n || cnt_clr) begin
      cnt_msg   <= '0;
      cnt_ord   <= '0;
      cnt_miss  <= '0;
      cnt_nohit <= '0;
    end else begin
      if (accept)   cnt_msg   <= sat_inc(cnt_msg);
      if (ev_ord)   cnt_ord   <= sat_inc(cnt_ord);
      if (ev_miss)  cnt_miss  <= sat_inc(cnt_miss);
      if (ev_nohit) cnt_nohit <= sat_inc(cnt_nohit);
    end
  end

endmodule

// File: tb/tb_tts_pipe.sv
// Bench for tts_pipe: two builds (RAM_LAT=1/SLOTS=4 and RAM_LAT=3/SLOTS=8) against
// a transaction-level model that predicts outcome, cycle timing and counters.
module tb_tts_pipe;

  logic        clk = 1'b0;
  logic        reset_n, cfg_en, cnt_clr, msg_valid, sel_b, ord_ready;
  logic [16:0] msg_sym_id;
  logic [63:0] msg_price;
  logic [31:0] msg_vol;
  logic        msg_side;

  logic         msg_ready_a, srd_en_a, trd_en_a, ord_valid_a;
  logic [13:0]  srd_addr_a, trd_addr_a;
  logic [63:0]  srd_data_a;
  logic [126:0] trd_data_a;
  logic [127:0] ord_data_a;
  logic [31:0]  cnt_msg_a, cnt_ord_a, cnt_miss_a, cnt_nohit_a;

  logic         msg_ready_b, srd_en_b, trd_en_b, ord_valid_b;
  logic [13:0]  srd_addr_b, trd_addr_b;
  logic [127:0] srd_data_b;
  logic [126:0] trd_data_b;
  logic [127:0] ord_data_b;
  logic [31:0]  cnt_msg_b, cnt_ord_b, cnt_miss_b, cnt_nohit_b;

  always #5 clk = ~clk;

  tts_pipe dut_a (
    .clk(clk), .reset_n(reset_n), .cfg_en(cfg_en), .cnt_clr(cnt_clr),
    .msg_valid(msg_valid & ~sel_b), .msg_ready(msg_ready_a),
    .msg_sym_id(msg_sym_id[15:0]), .msg_price(msg_price), .msg_vol(msg_vol), .msg_side(msg_side),
    .srd_en(srd_en_a), .srd_addr(srd_addr_a), .srd_data(srd_data_a),
    .trd_en(trd_en_a), .trd_addr(trd_addr_a), .trd_data(trd_data_a),
    .ord_valid(ord_valid_a), .ord_ready(ord_ready & ~sel_b), .ord_data(ord_data_a),
    .cnt_msg(cnt_msg_a), .cnt_ord(cnt_ord_a), .cnt_miss(cnt_miss_a), .cnt_nohit(cnt_nohit_a)
  );

  tts_pipe #(.SLOTS(8), .RAM_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .cfg_en(cfg_en), .cnt_clr(cnt_clr),
    .msg_valid(msg_valid & sel_b), .msg_ready(msg_ready_b),
    .msg_sym_id(msg_sym_id), .msg_price(msg_price), .msg_vol(msg_vol), .msg_side(msg_side),
    .srd_en(srd_en_b), .srd_addr(srd_addr_b), .srd_data(srd_data_b),
    .trd_en(trd_en_b), .trd_addr(trd_addr_b), .trd_data(trd_data_b),
    .ord_valid(ord_valid_b), .ord_ready(ord_ready & sel_b), .ord_data(ord_data_b),
    .cnt_msg(cnt_msg_b), .cnt_ord(cnt_ord_b), .cnt_miss(cnt_miss_b), .cnt_nohit(cnt_nohit_b)
  );

  // Observed view of whichever build is selected.
  logic [3:0]   m_ctl;
  logic [13:0]  m_srd_addr, m_trd_addr;
  logic [127:0] m_ord_data;
  logic [31:0]  m_cnt [4];
  assign m_ctl      = sel_b ? {srd_en_b, trd_en_b, ord_valid_b, msg_ready_b}
                            : {srd_en_a, trd_en_a, ord_valid_a, msg_ready_a};
  assign m_srd_addr = sel_b ? srd_addr_b : srd_addr_a;
  assign m_trd_addr = sel_b ? trd_addr_b : trd_addr_a;
  assign m_ord_data = sel_b ? ord_data_b : ord_data_a;
  assign m_cnt[0]   = sel_b ? cnt_msg_b   : cnt_msg_a;
  assign m_cnt[1]   = sel_b ? cnt_ord_b   : cnt_ord_a;
  assign m_cnt[2]   = sel_b ? cnt_miss_b  : cnt_miss_a;
  assign m_cnt[3]   = sel_b ? cnt_nohit_b : cnt_nohit_a;

  // Memory contents shared by the RAM models and the reference model.
  logic [63:0]  sym_mem_a [int];
  logic [127:0] sym_mem_b [int];
  logic [126:0] strat_mem [int];

  function automatic logic [63:0] rd_sym_a(input int a);
    return sym_mem_a.exists(a) ? sym_mem_a[a] : 64'd0;
  endfunction
  function automatic logic [127:0] rd_sym_b(input int a);
    return sym_mem_b.exists(a) ? sym_mem_b[a] : 128'd0;
  endfunction
  function automatic logic [126:0] rd_strat(input int a);
    return strat_mem.exists(a) ? strat_mem[a] : 127'd0;
  endfunction

  // Read ports: data appears RAM_LAT edges after an enabled read, zero otherwise.
  logic [63:0]  sp_a;
  logic [126:0] tp_a;
  logic [127:0] sp_b [3];
  logic [126:0] tp_b [3];
  always @(posedge clk) begin
    sp_a    <= srd_en_a ? rd_sym_a(int'(srd_addr_a)) : 64'd0;
    tp_a    <= trd_en_a ? rd_strat(int'(trd_addr_a)) : 127'd0;
    sp_b[0] <= srd_en_b ? rd_sym_b(int'(srd_addr_b)) : 128'd0;
    sp_b[1] <= sp_b[0];
    sp_b[2] <= sp_b[1];
    tp_b[0] <= trd_en_b ? rd_strat(int'(trd_addr_b)) : 127'd0;
    tp_b[1] <= tp_b[0];
    tp_b[2] <= tp_b[1];
  end
  assign srd_data_a = sp_a;
  assign trd_data_a = tp_a;
  assign srd_data_b = sp_b[2];
  assign trd_data_b = tp_b[2];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_cnt [2][4];
  string cnt_name [4] = '{"cnt_msg", "cnt_ord", "cnt_miss", "cnt_nohit"};

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic void zero_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) exp_cnt[d][i] = 32'd0;
  endfunction

  function automatic logic [15:0] model_entry(input bit b, input int id);
    int slots = b ? 8 : 4;
    logic [127:0] w;
    w = b ? rd_sym_b(id / slots) : {64'd0, rd_sym_a(id / slots)};
    return 16'(w >> ((id % slots) * 16));
  endfunction

  task automatic set_entry(input bit b, input int id, input logic [15:0] e);
    logic [127:0] w;
    int slots = b ? 8 : 4;
    w = b ? rd_sym_b(id / slots) : {64'd0, rd_sym_a(id / slots)};
    w[(id % slots) * 16 +: 16] = e;
    if (b) sym_mem_b[id / slots] = w;
    else   sym_mem_a[id / slots] = w[63:0];
  endtask

  // One message end to end. rdy >= 0: ord_ready rises rdy cycles after ord_valid.
  // rdy < 0: reset is applied two cycles into the OUT phase.
  task automatic run_msg(input bit b, input int id, input logic [63:0] px, input logic [31:0] vol,
                         input bit side, input int rdy, input bit clr, input bit drop);
    int lat, slots, idx, trd_k, ord_k, idle_k, last_k;
    logic [15:0] e;
    logic [126:0] sw;
    logic [127:0] exp_ord;
    logic [3:0] exp_ctl;
    bit valid, hit, abort;
    lat   = b ? 3 : 1;
    slots = b ? 8 : 4;
    e     = model_entry(b, id);
    valid = e[15];
    idx   = int'(e[13:0]);
    sw    = rd_strat(idx);
    hit   = valid && (side ? (px >= sw[95:32]) : (px <= sw[95:32])) && (vol >= sw[31:0]);
    abort = hit && (rdy < 0);
    exp_ord = {sw[126:96], side, px, vol};
    trd_k  = valid ? 2 + lat : -1;
    ord_k  = hit ? 3 + 2 * lat : -1;
    idle_k = !valid ? 2 + lat : (!hit ? 3 + 2 * lat : (abort ? -1 : ord_k + rdy + 1));
    last_k = abort ? ord_k + 3 : idle_k;

    if (sel_b != b) begin
      @(negedge clk);
      sel_b = b;
    end
    @(negedge clk);
    vectors++;
    if (m_ctl[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready id=%0d: got %b want 1", id, m_ctl[0]);
    end
    msg_valid  = 1'b1;
    msg_sym_id = 17'(id);
    msg_price  = px;
    msg_vol    = vol;
    msg_side   = side;
    cnt_clr    = clr;
    if (clr) zero_model();
    else     exp_cnt[b][0] = sat(exp_cnt[b][0]);

    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      if (k == 1) begin
        msg_valid = 1'b0;
        cnt_clr   = 1'b0;
      end
      if (abort && k == ord_k + 3) begin
        vectors++;
        if (m_ctl !== 4'b0001) begin
          miscompares++;
          $display("FAIL reset_in_out_ctl: got %b want 0001", m_ctl);
        end
        for (int i = 0; i < 4; i++) begin
          vectors++;
          if (m_cnt[i] !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_in_out_%s: got %h want 0", cnt_name[i], m_cnt[i]);
          end
        end
        reset_n = 1'b1;
        zero_model();
      end else begin
        exp_ctl = {k == 1, k == trd_k,
                   hit && k >= ord_k && (rdy < 0 || k <= ord_k + rdy),
                   k == idle_k && !drop};
        vectors++;
        if (m_ctl !== exp_ctl) begin
          miscompares++;
          $display("FAIL ctl id=%0d cyc=T+%0d {srd,trd,ord_v,rdy}: got %b want %b", id, k, m_ctl, exp_ctl);
        end
        if (k == 1) begin
          vectors++;
          if (m_srd_addr !== 14'(id / slots)) begin
            miscompares++;
            $display("FAIL srd_addr id=%0d: got %0d want %0d", id, m_srd_addr, id / slots);
          end
        end
        if (k == trd_k) begin
          vectors++;
          if (m_trd_addr !== 14'(idx)) begin
            miscompares++;
            $display("FAIL trd_addr id=%0d: got %0d want %0d", id, m_trd_addr, idx);
          end
        end
        if (exp_ctl[1]) begin
          vectors++;
          if (m_ord_data !== exp_ord) begin
            miscompares++;
            $display("FAIL ord_data id=%0d cyc=T+%0d: got %h want %h", id, k, m_ord_data, exp_ord);
          end
        end
        if (hit && rdy >= 0) ord_ready = (k == ord_k + rdy);
        if (abort && k == ord_k + 2) reset_n = 1'b0;
        if (drop && k == 2) begin
          cfg_en    = 1'b0;
          msg_valid = 1'b1;
        end
      end
    end

    if (!abort) begin
      if (!valid)    exp_cnt[b][2] = sat(exp_cnt[b][2]);
      else if (!hit) exp_cnt[b][3] = sat(exp_cnt[b][3]);
      else           exp_cnt[b][1] = sat(exp_cnt[b][1]);
    end
    if (drop) begin
      repeat (3) begin
        @(negedge clk);
        vectors++;
        if (m_ctl !== 4'b0000) begin
          miscompares++;
          $display("FAIL cfg_off_no_accept: got %b want 0000", m_ctl);
        end
      end
      msg_valid = 1'b0;
      cfg_en    = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (m_cnt[i] !== exp_cnt[b][i]) begin
        miscompares++;
        $display("FAIL %s id=%0d: got %h want %h", cnt_name[i], id, m_cnt[i], exp_cnt[b][i]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cfg_en = 1'b1; cnt_clr = 1'b0; msg_valid = 1'b0; sel_b = 1'b0;
    ord_ready = 1'b0; msg_sym_id = '0; msg_price = '0; msg_vol = '0; msg_side = 1'b0;
    zero_model();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      sel_b = s[0];
      #1;
      vectors++;
      if ({m_ctl, m_srd_addr, m_trd_addr, m_ord_data} !== {4'b0001, 14'd0, 14'd0, 128'd0}) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: got ctl=%b srd=%h trd=%h ord=%h want ctl=0001 rest 0",
                 s, m_ctl, m_srd_addr, m_trd_addr, m_ord_data);
      end
      vectors++;
      if ({m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]} !== 128'd0) begin
        miscompares++;
        $display("FAIL reset_counters dut%0d: got %h %h %h %h want 0", s, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
      end
    end
  endtask

  task automatic test_directed();
    run_msg(0, 1, 64'd99,  32'd10, 1'b0, 0, 1'b0, 1'b0);  // ask hit
    run_msg(0, 1, 64'd99,  32'd10, 1'b1, 0, 1'b0, 1'b0);  // bid below limit: no hit
    run_msg(0, 1, 64'd100, 32'd10, 1'b1, 0, 1'b0, 1'b0);  // bid at limit: hit
    run_msg(0, 1, 64'd99,  32'd9,  1'b0, 0, 1'b0, 1'b0);  // volume one short
    run_msg(0, 1, 64'd100, 32'd10, 1'b0, 0, 1'b0, 1'b0);  // ask at limit: hit
    run_msg(0, 1, 64'd101, 32'd10, 1'b0, 0, 1'b0, 1'b0);  // ask above limit
    run_msg(0, 6, 64'd99,  32'd10, 1'b0, 0, 1'b0, 1'b0);  // invalid entry: miss
  endtask

  task automatic test_backpressure();
    run_msg(0, 1, 64'd50, 32'd500, 1'b0, 7, 1'b0, 1'b0);
  endtask

  task automatic test_clr_on_accept();
    run_msg(0, 1, 64'd99, 32'd10, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_cfg_drop();
    run_msg(0, 1, 64'd100, 32'd10, 1'b1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut_a.cnt_msg = 32'hFFFF_FFFD;
    #1;
    release dut_a.cnt_msg;
    exp_cnt[0][0] = 32'hFFFF_FFFD;
    repeat (3) run_msg(0, 6, 64'd1, 32'd1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_lat3_slots8();
    run_msg(1, 8'h1B, 64'd99, 32'd10, 1'b0, 0, 1'b0, 1'b0);
    run_msg(1, 8'h1A, 64'd99, 32'd10, 1'b0, 0, 1'b0, 1'b0);
    run_msg(1, 8'h1B, 64'd99, 32'd10, 1'b1, 0, 1'b0, 1'b0);
    run_msg(1, 8'h1B, 64'd7,  32'd99, 1'b0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 52; n++) begin
      bit b = (n >= 40);
      int id = b ? int'($urandom_range(64, 95)) : int'($urandom_range(32, 63));
      run_msg(b, id, 64'($urandom_range(900, 2100)), 32'($urandom_range(0, 60)),
              1'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_in_out();
    run_msg(0, 1, 64'd99, 32'd10, 1'b0, -1, 1'b0, 1'b0);
    run_msg(0, 1, 64'd99, 32'd10, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_entry(0, 1, 16'h8005);
    set_entry(0, 6, 16'h0005);
    set_entry(1, 8'h1B, 16'h8005);
    set_entry(1, 8'h1A, 16'h4005);
    strat_mem[5] = {31'h1234, 64'd100, 32'd10};
    for (int i = 16; i < 64; i++)
      strat_mem[i] = {31'($urandom), 64'($urandom_range(1000, 2000)), 32'($urandom_range(10, 50))};
    for (int id = 32; id < 64; id++)
      set_entry(0, id, {1'($urandom_range(0, 3) != 0), 1'($urandom), 14'($urandom_range(16, 63))});
    for (int id = 64; id < 96; id++)
      set_entry(1, id, {1'($urandom_range(0, 3) != 0), 1'($urandom), 14'($urandom_range(16, 63))});

    test_reset();
    test_directed();
    test_backpressure();
    test_clr_on_accept();
    test_cfg_drop();
    test_saturation();
    test_lat3_slots8();
    test_random();
    test_reset_in_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
